// File: rtl/arm_position_recorder.sv
// Arm position recorder: captures packed X/Y/Z samples into the position RAM
// on a single-shot pulse or a periodic tick, via a req/ack write port.
module arm_position_recorder #(
    parameter int DATA_WIDTH     = 30,
    parameter int AXIS_WIDTH     = 10,
    parameter int ADDRESS_WIDTH  = 4,
    parameter int SAMPLE_DIVIDER = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXIS_WIDTH-1:0]    x_in,
    input  logic [AXIS_WIDTH-1:0]    y_in,
    input  logic [AXIS_WIDTH-1:0]    z_in,
    input  logic                     record_pulse,
    input  logic                     clear_pulse,
    input  logic                     cont_record,
    output logic                     wr_req,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_ack,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     full,
    output logic                     busy,
    output logic                     overrun
);

    localparam int CW   = ADDRESS_WIDTH + 1;
    localparam int DIVW = (SAMPLE_DIVIDER > 2) ? $clog2(SAMPLE_DIVIDER) : 1;

    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'((2 ** ADDRESS_WIDTH) - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(2 ** ADDRESS_WIDTH);
    localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);
    localparam logic [DIVW-1:0] DIV_MAX  = DIVW'(SAMPLE_DIVIDER - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [DIVW-1:0]          div_q, div_d;
    logic                     ovr_q, ovr_d;
    logic                     pend_q, pend_d;

    logic div_run;
    logic tick;
    logic trigger;
    logic clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            div_q   <= '0;
            ovr_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            div_q   <= div_d;
            ovr_q   <= ovr_d;
            pend_q  <= pend_d;
        end
    end

    // Divider only runs while continuous capture can still make progress.
    always_comb begin
        div_run = cont_record && (state_q != FULL);
        tick    = div_run && (div_q == DIV_MAX);
        div_d   = '0;
        if (div_run && (div_q != DIV_MAX)) begin
            div_d = div_q + DIV_ONE;
        end
    end

    assign trigger = record_pulse | tick;
    assign clr     = clear_pulse | pend_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        pend_d  = pend_q;

        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    count_d = '0;
                    ovr_d   = 1'b0;
                    pend_d  = 1'b0;
                end else if (trigger) begin
                    data_d  = {x_in, y_in, z_in};
                    addr_d  = count_q[ADDRESS_WIDTH-1:0];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // A clear here is deferred until the write handshake finishes.
                if (clear_pulse) begin
                    pend_d = 1'b1;
                end
                if (trigger) begin
                    ovr_d = 1'b1;
                end
                if (wr_ack) begin
                    count_d = count_q + CNT_ONE;
                    state_d = (count_q == CNT_LAST) ? FULL : IDLE;
                end
            end
            FULL: begin
                if (clr) begin
                    count_d = '0;
                    ovr_d   = 1'b0;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_req  = (state_q == WRITE);
    assign busy    = (state_q == WRITE);
    assign wr_addr = addr_q;
    assign wr_data = data_q;
    assign count   = count_q;
    assign full    = (count_q == CNT_FULL);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_arm_position_recorder.sv
// Directed self-checking bench for arm_position_recorder.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_arm_position_recorder;

    localparam int DW = 30;
    localparam int AW = 10;
    localparam int RW = 4;
    localparam int SD = 8;

    logic          clk;
    logic          rst;
    logic [AW-1:0] x_in, y_in, z_in;
    logic          record_pulse, clear_pulse, cont_record;
    logic          wr_req;
    logic [RW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic [RW:0]   count;
    logic          full, busy, overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_log[$];

    arm_position_recorder #(
        .DATA_WIDTH(DW),
        .AXIS_WIDTH(AW),
        .ADDRESS_WIDTH(RW),
        .SAMPLE_DIVIDER(SD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .x_in(x_in),
        .y_in(y_in),
        .z_in(z_in),
        .record_pulse(record_pulse),
        .clear_pulse(clear_pulse),
        .cont_record(cont_record),
        .wr_req(wr_req),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ack(wr_ack),
        .count(count),
        .full(full),
        .busy(busy),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_req && wr_ack) ack_log.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_record();
        record_pulse = 1'b1;
        @(negedge clk);
        record_pulse = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_pulse = 1'b1;
        @(negedge clk);
        clear_pulse = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(2);
        checks++;
        if (wr_req !== 1'b0 || busy !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl req=%b busy=%b full=%b want 0 0 0",
                     wr_req, busy, full);
        end
        checks++;
        if (count !== 5'd0 || overrun !== 1'b0 ||
            wr_addr !== 4'd0 || wr_data !== 30'd0) begin
            errors++;
            $display("FAIL reset_regs cnt=%0d ovr=%b addr=%0d data=%h want zeros",
                     count, overrun, wr_addr, wr_data);
        end
        rst = 1'b1;
        tick(1);
    endtask

    task automatic test_single_capture();
        int n0;
        x_in = 10'h155; y_in = 10'h0AA; z_in = 10'h3FF;
        wr_ack = 1'b1;
        n0 = ack_log.size();
        pulse_record();
        checks++;
        if (wr_req !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 30'h1552ABFF) begin
            errors++;
            $display("FAIL single_req req=%b addr=%0d data=%h want 1 0 1552abff",
                     wr_req, wr_addr, wr_data);
        end
        tick(1);
        checks++;
        if (wr_req !== 1'b0 || count !== 5'd1) begin
            errors++;
            $display("FAIL single_done req=%b cnt=%0d want 0 1", wr_req, count);
        end
        tick(2);
        checks++;
        if (ack_log.size() - n0 != 1) begin
            errors++;
            $display("FAIL single_writes got %0d want 1", ack_log.size() - n0);
        end
        wr_ack = 1'b0;
    endtask

    task automatic test_clear_wins();
        x_in = 10'h001; y_in = 10'h002; z_in = 10'h003;
        record_pulse = 1'b1;
        clear_pulse  = 1'b1;
        tick(1);
        record_pulse = 1'b0;
        clear_pulse  = 1'b0;
        checks++;
        if (wr_req !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL clear_wins req=%b cnt=%0d want 0 0", wr_req, count);
        end
        tick(1);
    endtask

    task automatic test_fill();
        int bad_addr = 0;
        int bad_cnt = 0;
        wr_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            x_in = AW'(i); y_in = AW'(i + 16); z_in = AW'(i + 32);
            pulse_record();
            if (wr_req !== 1'b1 || wr_addr !== RW'(i) ||
                wr_data !== {AW'(i), AW'(i + 16), AW'(i + 32)}) bad_addr++;
            tick(2);
            wr_ack = 1'b1;
            tick(1);
            wr_ack = 1'b0;
            if (wr_req !== 1'b0 || count !== 5'(i + 1)) bad_cnt++;
        end
        checks++;
        if (bad_addr != 0) begin
            errors++;
            $display("FAIL fill_addr bad_entries=%0d want 0", bad_addr);
        end
        checks++;
        if (bad_cnt != 0) begin
            errors++;
            $display("FAIL fill_count bad_steps=%0d want 0", bad_cnt);
        end
        checks++;
        if (full !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL fill_full full=%b cnt=%0d want 1 16", full, count);
        end
        wr_ack = 1'b1;
        pulse_record();
        tick(2);
        checks++;
        if (wr_req !== 1'b0 || overrun !== 1'b0 || count !== 5'd16) begin
            errors++;
            $display("FAIL full_ignore req=%b ovr=%b cnt=%0d want 0 0 16",
                     wr_req, overrun, count);
        end
        wr_ack = 1'b0;
        pulse_clear();
        checks++;
        if (full !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL full_clear full=%b cnt=%0d want 0 0", full, count);
        end
    endtask

    task automatic test_overrun();
        int n0;
        wr_ack = 1'b0;
        n0 = ack_log.size();
        pulse_record();
        tick(1);
        pulse_record();
        checks++;
        if (overrun !== 1'b1 || wr_req !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set ovr=%b req=%b want 1 1", overrun, wr_req);
        end
        wr_ack = 1'b1;
        tick(1);
        wr_ack = 1'b0;
        tick(3);
        checks++;
        if (ack_log.size() - n0 != 1 || count !== 5'd1 || wr_req !== 1'b0) begin
            errors++;
            $display("FAIL overrun_one writes=%0d cnt=%0d req=%b want 1 1 0",
                     ack_log.size() - n0, count, wr_req);
        end
        pulse_clear();
        checks++;
        if (overrun !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL overrun_clear ovr=%b cnt=%0d want 0 0", overrun, count);
        end
    endtask

    task automatic test_clear_during_write();
        wr_ack = 1'b0;
        x_in = 10'h011; y_in = 10'h022; z_in = 10'h033;
        pulse_record();
        pulse_clear();
        tick(3);
        checks++;
        if (wr_req !== 1'b1 || wr_addr !== 4'd0 ||
            wr_data !== {10'h011, 10'h022, 10'h033}) begin
            errors++;
            $display("FAIL cdw_hold req=%b addr=%0d data=%h want 1 0 %h",
                     wr_req, wr_addr, wr_data, {10'h011, 10'h022, 10'h033});
        end
        wr_ack = 1'b1;
        tick(1);
        wr_ack = 1'b0;
        tick(1);
        checks++;
        if (wr_req !== 1'b0 || count !== 5'd0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL cdw_clear req=%b cnt=%0d ovr=%b want 0 0 0",
                     wr_req, count, overrun);
        end
        tick(2);
        checks++;
        if (count !== 5'd0 || wr_req !== 1'b0) begin
            errors++;
            $display("FAIL cdw_stay cnt=%0d req=%b want 0 0", count, wr_req);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        wr_ack = 1'b1;
        n0 = ack_log.size();
        for (int i = 0; i < 4; i++) begin
            pulse_record();
            tick(1);
        end
        checks++;
        if (count !== 5'd4 || ack_log.size() - n0 != 4) begin
            errors++;
            $display("FAIL b2b cnt=%0d writes=%0d want 4 4",
                     count, ack_log.size() - n0);
        end
        checks++;
        if (ack_log[n0 + 3] - ack_log[n0] != 6) begin
            errors++;
            $display("FAIL b2b_rate span=%0d want 6",
                     ack_log[n0 + 3] - ack_log[n0]);
        end
        wr_ack = 1'b0;
        pulse_clear();
    endtask

    task automatic test_continuous();
        int n0;
        int start;
        int guard;
        wr_ack = 1'b1;
        n0 = ack_log.size();
        start = cyc;
        cont_record = 1'b1;
        guard = 0;
        while (ack_log.size() - n0 < 3 && guard < 100) begin
            tick(1);
            guard++;
        end
        cont_record = 1'b0;
        checks++;
        if (ack_log.size() - n0 < 3) begin
            errors++;
            $display("FAIL cont_timeout writes=%0d want 3", ack_log.size() - n0);
        end else begin
            checks++;
            if (ack_log[n0] != start + SD ||
                ack_log[n0 + 1] - ack_log[n0] != SD ||
                ack_log[n0 + 2] - ack_log[n0 + 1] != SD) begin
                errors++;
                $display("FAIL cont_period t0=%0d t1=%0d t2=%0d want %0d +%0d +%0d",
                         ack_log[n0], ack_log[n0 + 1], ack_log[n0 + 2],
                         start + SD, SD, SD);
            end
        end
        tick(20);
        checks++;
        if (ack_log.size() - n0 != 3 || count !== 5'd3) begin
            errors++;
            $display("FAIL cont_stop writes=%0d cnt=%0d want 3 3",
                     ack_log.size() - n0, count);
        end
        n0 = ack_log.size();
        start = cyc;
        cont_record = 1'b1;
        guard = 0;
        while (count !== 5'd16 && guard < 300) begin
            tick(1);
            guard++;
        end
        checks++;
        if (ack_log.size() - n0 < 1 || ack_log[n0] != start + SD) begin
            errors++;
            $display("FAIL cont_restart first_ack_ok=%0d want divider restart",
                     (ack_log.size() - n0 >= 1) ? ack_log[n0] - start : -1);
        end
        tick(30);
        checks++;
        if (full !== 1'b1 || ack_log.size() - n0 != 13 ||
            wr_req !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL cont_full full=%b writes=%0d req=%b ovr=%b want 1 13 0 0",
                     full, ack_log.size() - n0, wr_req, overrun);
        end
        cont_record = 1'b0;
        wr_ack = 1'b0;
        pulse_clear();
    endtask

    task automatic test_async_reset();
        wr_ack = 1'b1;
        pulse_record();
        tick(1);
        wr_ack = 1'b0;
        pulse_record();
        tick(1);
        pulse_record();
        checks++;
        if (wr_req !== 1'b1 || overrun !== 1'b1 || count !== 5'd1) begin
            errors++;
            $display("FAIL areset_pre req=%b ovr=%b cnt=%0d want 1 1 1",
                     wr_req, overrun, count);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (wr_req !== 1'b0 || count !== 5'd0 ||
            overrun !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset req=%b cnt=%0d ovr=%b busy=%b want 0 0 0 0",
                     wr_req, count, overrun, busy);
        end
        tick(1);
        rst = 1'b1;
        tick(1);
    endtask

    initial begin
        rst = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;
        record_pulse = 1'b0;
        clear_pulse = 1'b0;
        cont_record = 1'b0;
        wr_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_capture();
        pulse_clear();
        test_clear_wins();
        test_fill();
        test_overrun();
        test_clear_during_write();
        test_back_to_back();
        test_continuous();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
